// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional SERIAL_ADD_OVF_EN build adds a signed-overflow flag to the result.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-counter width; it must hold WIDTH because it advances past the last bit.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between the requesting unit and serial_add_ctrl.
// ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout
    );

endinterface

// File: rtl/fa_cell.sv
// Single combinational full-adder cell shared across all bit positions.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, WIDTH cycles per add, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output bus.ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, sum_q;
    logic             carry_q, cout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fa_s, fa_co;
    logic             accept, last_bit;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept   = (state_q == IDLE) && bus.start;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sum bits enter at the MSB so the LSB-first result ends up in place after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_q <= bus.cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_q <= fa_co;
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) cout_q <= fa_co;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the MSB cycle carry_q is the carry into the sign bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ovf_q <= 1'b0;
        else if (accept)                     ovf_q <= 1'b0;
        else if (state_q == RUN && last_bit) ovf_q <= carry_q ^ fa_co;
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that time-multiplexes a single 1-bit full-adder cell across a WIDTH-bit addition, LSB first, one bit per clock.
- Owns operand shift registers, the carry flip-flop, a bit counter and a start/busy/done handshake.
- Sits between a requesting unit (ALU sequencer, testbench driver) and the shared full-adder cell.
- Trades latency for area: one adder cell for any WIDTH.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users).

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset; deassertion synchronised externally.
start  input  1  request pulse/level; sampled only in IDLE.
a  input  WIDTH  operand A, captured on accepted start.
b  input  WIDTH  operand B, captured on accepted start.
cin  input  1  carry-in, captured on accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  result register; holds until next accepted start.
cout  output  1  final carry-out; holds with sum.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, counter=0, carry FF=0, shift regs=0.
- States:
  - IDLE: start=1 at edge T0 -> load a_sh=a, b_sh=b, carry=cin, counter=0, sum=0 -> RUN.
  - RUN: each edge computes fa(a_sh[0], b_sh[0], carry).
    - sum bit shifted in at MSB of sum register (sum >> 1 | s<<(WIDTH-1)).
    - carry <= fa carry.
    - a_sh, b_sh shift right; counter++.
    - When counter==WIDTH-1 at an edge (i.e. edge T_WIDTH): that bit is processed, cout <= fa carry -> DONE.
  - DONE: done=1, busy=1 for exactly one cycle -> IDLE unconditionally.
- Latency: start sampled at edge T0; done visible after edge T_WIDTH+... precisely, done high in the cycle following edge T_WIDTH, i.e. WIDTH+1 cycles after the start edge. Back-to-back throughput: one add per WIDTH+2 cycles.
- start while busy=1: ignored, no queuing; operands not recaptured.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- sum/cout are visible as partial values during RUN; they are valid only while done=1 and thereafter until the next accepted start.
- Arithmetic: unsigned modulo 2^WIDTH; {cout,sum} = a + b + cin exactly.
- Reset mid-operation: abort immediately; all outputs return to reset values; no done pulse.
- Full-adder cell is purely combinational; no other path from inputs to outputs (all outputs registered).

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined: adds output port ovf (1 bit), reset 0.
  - On the MSB cycle, ovf <= carry_in_to_MSB XOR fa carry-out (signed two's-complement overflow).
  - Held alongside sum/cout; cleared on accepted start.
- Undefined: port and logic absent; interface otherwise identical.

Decomposition:
- Shared package serial_add_pkg:
  - state enum typedef (IDLE, RUN, DONE; 2-bit encoding 00/01/10).
  - default WIDTH constant.
- One sub-module natural: fa_cell (a, b, ci -> s, co; s = a^b^ci, co = majority), instantiated once.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start 1 cycle -> done exactly 9 cycles after start edge, sum=0x8D, cout=0, busy high 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start pulsed again at cycle 3 of RUN with a=0x01, b=0x01 -> ignored; result of the original add unchanged; no extra done.
- rst_n driven low at RUN cycle 4 -> busy/done/sum/cout=0 asynchronously; no done pulse; a new start after release gives a correct result.
- start held high for 30 cycles with fixed a=0x10, b=0x20 -> done pulses every 10 cycles, sum=0x30 each time.
- SERIAL_ADD_OVF_EN defined: a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1; a=0x05, b=0x03 -> ovf=0.
